// File: rtl/csr_regfile.sv
// csr_regfile: LoongArch control/status register file.
//   Takes CSR writes, exception commits and ertn commits from WB. Returns the CSR read data,
//   the trap entry, the ertn target, pending-interrupt status, the stable counter and TID.
//   Optional timer (TCFG/TVAL/TICLR, ESTAT.IS[11]) is built only when CSR_TIMER_EN is defined.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   csr_raddr / csr_rdata           combinational read port (ID stage)
//   csr_we/waddr/wdata/wmask        masked write port (WB stage)
//   excp_flush, ertn_flush          trap commit / return commit
//   csr_ecode, csr_esubcode         exception cause
//   pc_to_era, error_badv(_pc)      faulting PC and optional bad virtual address
//   hw_int_in, ipi_int_in           level interrupt lines
//   ex_entry, ertn_pc, has_int      trap target, return target, interrupt pending
//   counter_value, counter_id       64-bit stable counter, TID
module csr_regfile #(
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] csr_raddr,
    output logic [31:0] csr_rdata,
    input  logic        csr_we,
    input  logic [13:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] csr_wmask,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic [5:0]  csr_ecode,
    input  logic [8:0]  csr_esubcode,
    input  logic [31:0] pc_to_era,
    input  logic        error_badv,
    input  logic [31:0] error_badv_pc,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_pc,
    output logic        has_int,
    output logic [63:0] counter_value,
    output logic [31:0] counter_id
);

    localparam logic [13:0] CsrCrmd   = 14'h000;
    localparam logic [13:0] CsrPrmd   = 14'h001;
    localparam logic [13:0] CsrEcfg   = 14'h004;
    localparam logic [13:0] CsrEstat  = 14'h005;
    localparam logic [13:0] CsrEra    = 14'h006;
    localparam logic [13:0] CsrBadv   = 14'h007;
    localparam logic [13:0] CsrEentry = 14'h00C;
    localparam logic [13:0] CsrSave0  = 14'h030;
    localparam logic [13:0] CsrSave1  = 14'h031;
    localparam logic [13:0] CsrSave2  = 14'h032;
    localparam logic [13:0] CsrSave3  = 14'h033;
    localparam logic [13:0] CsrTid    = 14'h040;
`ifdef CSR_TIMER_EN
    localparam logic [13:0] CsrTcfg   = 14'h041;
    localparam logic [13:0] CsrTval   = 14'h042;
    localparam logic [13:0] CsrTiclr  = 14'h044;
`endif

    logic [4:0]  crmd_q;
    logic [2:0]  prmd_q;
    logic [12:0] ecfg_lie_q;
    logic [1:0]  estat_sw_q;
    logic [7:0]  estat_hw_q;
    logic        estat_ipi_q;
    logic [5:0]  estat_ecode_q;
    logic [8:0]  estat_esub_q;
    logic [31:0] era_q;
    logic [31:0] badv_q;
    logic [25:0] eentry_q;
    logic [31:0] save_q [4];
    logic [31:0] tid_q;
    logic [63:0] counter_q;
    logic        ti;

    logic [31:0] estat_rd;
    logic [13:0] rd_addr [2];
    logic [31:0] rd_val  [2];
    logic [31:0] wr_new;
    logic        wr_en;

`ifdef CSR_TIMER_EN
    logic [31:0] tcfg_q;
    logic [31:0] tval_q;
    logic        ti_q;
    logic        tcfg_load;
    logic        tval_expire;
    logic        ti_clear;
`endif

    assign estat_rd = {1'b0, estat_esub_q, estat_ecode_q, 3'b000, estat_ipi_q, ti, 1'b0,
                       estat_hw_q, estat_sw_q};

    // Port 0 serves the ID read; port 1 fetches the old value under the write address so a
    // masked write can merge against it.
    assign rd_addr[0] = csr_raddr;
    assign rd_addr[1] = csr_waddr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p] = 32'h0;
            case (rd_addr[p])
                CsrCrmd:   rd_val[p] = {27'h0, crmd_q};
                CsrPrmd:   rd_val[p] = {29'h0, prmd_q};
                CsrEcfg:   rd_val[p] = {19'h0, ecfg_lie_q};
                CsrEstat:  rd_val[p] = estat_rd;
                CsrEra:    rd_val[p] = era_q;
                CsrBadv:   rd_val[p] = badv_q;
                CsrEentry: rd_val[p] = {eentry_q, 6'h0};
                CsrSave0:  rd_val[p] = save_q[0];
                CsrSave1:  rd_val[p] = save_q[1];
                CsrSave2:  rd_val[p] = save_q[2];
                CsrSave3:  rd_val[p] = save_q[3];
                CsrTid:    rd_val[p] = tid_q;
`ifdef CSR_TIMER_EN
                CsrTcfg:   rd_val[p] = tcfg_q;
                CsrTval:   rd_val[p] = tval_q;
`endif
                default:   rd_val[p] = 32'h0;
            endcase
        end
    end

    assign csr_rdata = rd_val[0];
    assign wr_new    = (rd_val[1] & ~csr_wmask) | (csr_wdata & csr_wmask);
    // Trap and return commits take priority over a same-cycle software write.
    assign wr_en     = csr_we & ~excp_flush & ~ertn_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_q        <= 5'h08;
            prmd_q        <= 3'h0;
            ecfg_lie_q    <= 13'h0;
            estat_sw_q    <= 2'h0;
            estat_hw_q    <= 8'h0;
            estat_ipi_q   <= 1'b0;
            estat_ecode_q <= 6'h0;
            estat_esub_q  <= 9'h0;
            era_q         <= 32'h0;
            badv_q        <= 32'h0;
            eentry_q      <= 26'h0;
            save_q[0]     <= 32'h0;
            save_q[1]     <= 32'h0;
            save_q[2]     <= 32'h0;
            save_q[3]     <= 32'h0;
            tid_q         <= TID_RESET;
            counter_q     <= 64'h0;
        end else begin
            counter_q   <= counter_q + 64'd1;
            estat_hw_q  <= hw_int_in;
            estat_ipi_q <= ipi_int_in;
            if (excp_flush) begin
                prmd_q        <= crmd_q[2:0];
                crmd_q[2:0]   <= 3'b000;
                estat_ecode_q <= csr_ecode;
                estat_esub_q  <= csr_esubcode;
                era_q         <= pc_to_era;
                if (error_badv) begin
                    badv_q <= error_badv_pc;
                end
            end else if (ertn_flush) begin
                crmd_q[2:0] <= prmd_q;
            end else if (wr_en) begin
                case (csr_waddr)
                    CsrCrmd:   crmd_q     <= wr_new[4:0];
                    CsrPrmd:   prmd_q     <= wr_new[2:0];
                    CsrEcfg:   ecfg_lie_q <= wr_new[12:0] & 13'h1BFF;
                    CsrEstat:  estat_sw_q <= wr_new[1:0];
                    CsrEra:    era_q      <= wr_new;
                    CsrBadv:   badv_q     <= wr_new;
                    CsrEentry: eentry_q   <= wr_new[31:6];
                    CsrSave0:  save_q[0]  <= wr_new;
                    CsrSave1:  save_q[1]  <= wr_new;
                    CsrSave2:  save_q[2]  <= wr_new;
                    CsrSave3:  save_q[3]  <= wr_new;
                    CsrTid:    tid_q      <= wr_new;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_TIMER_EN
    assign tcfg_load   = wr_en && (csr_waddr == CsrTcfg) && wr_new[0];
    // The last decrement step (TVAL==1) raises TI, whether it lands on 0 or reloads.
    assign tval_expire = tcfg_q[0] && (tval_q == 32'd1) && !tcfg_load;
    assign ti_clear    = wr_en && (csr_waddr == CsrTiclr) && csr_wdata[0] && csr_wmask[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg_q <= 32'h0;
            tval_q <= 32'h0;
            ti_q   <= 1'b0;
        end else begin
            if (wr_en && (csr_waddr == CsrTcfg)) begin
                tcfg_q <= wr_new;
            end
            if (tcfg_load) begin
                tval_q <= {wr_new[31:2], 2'b00};
            end else if (tcfg_q[0] && (tval_q != 32'h0)) begin
                if ((tval_q == 32'd1) && tcfg_q[1]) begin
                    tval_q <= {tcfg_q[31:2], 2'b00};
                end else begin
                    tval_q <= tval_q - 32'd1;
                end
            end
            if (tval_expire) begin
                ti_q <= 1'b1;
            end else if (ti_clear) begin
                ti_q <= 1'b0;
            end
        end
    end

    assign ti = ti_q;
`else
    assign ti = 1'b0;
`endif

    assign has_int       = crmd_q[2] & |(estat_rd[12:0] & ecfg_lie_q);
    assign ex_entry      = {eentry_q, 6'h0};
    assign ertn_pc       = era_q;
    assign counter_value = counter_q;
    assign counter_id    = tid_q;

endmodule
